// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with runtime baud divisor, parity and stop-bit
// configuration, 2-of-3 mid-bit majority voting and a single-entry output register.
module uart_rx_cfg #(
  parameter int DATA_W = 8,
  parameter int OVS    = 16,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  input  logic              rx_serial,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int OW = $clog2(OVS);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [OW-1:0] SAMP0 = OW'(OVS / 2 - 1);
  localparam logic [OW-1:0] SAMP1 = OW'(OVS / 2);
  localparam logic [OW-1:0] SAMP2 = OW'(OVS / 2 + 1);
  localparam logic [OW-1:0] LAST  = OW'(OVS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [OW-1:0]     os_q, os_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              stop_idx_q, stop_idx_d;
  logic [1:0]        samp_q, samp_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_en_q, par_en_d, par_odd_q, par_odd_d, two_stop_q, two_stop_d;
  logic              perr_acc_q, perr_acc_d, ferr_acc_q, ferr_acc_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic              busy_q, busy_d;

  logic tick, start_edge, maj, rx_s;

  assign rx_s       = sync2_q;
  assign tick       = (div_q == baud_div);
  assign start_edge = prev_q & ~rx_s;
  assign maj        = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

  always_comb begin
    state_d    = state_q;
    sync1_d    = rx_serial;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    div_d      = div_q;
    os_d       = os_q;
    bit_d      = bit_q;
    stop_idx_d = stop_idx_q;
    samp_d     = samp_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    two_stop_d = two_stop_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    done_d     = 1'b0;
    data_d     = data_q;
    valid_d    = valid_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    ovr_d      = ovr_q;

    if (state_q == IDLE) begin
      div_d = '0;
      os_d  = '0;
      if (start_edge) begin
        state_d    = START;
        par_en_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
        par_odd_d  = (parity_mode == 2'b10);
        two_stop_d = stop2;
        perr_acc_d = 1'b0;
        ferr_acc_d = 1'b0;
        bit_d      = '0;
        stop_idx_d = 1'b0;
      end
    end else begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
      if (tick) begin
        os_d = (os_q == LAST) ? '0 : os_q + OW'(1);
        if (os_q == SAMP0) samp_d[0] = rx_s;
        if (os_q == SAMP1) samp_d[1] = rx_s;
        // Each bit is decided on its third sample; bit boundaries stay on the OVS grid.
        unique case (state_q)
          START: begin
            if (os_q == SAMP2 && maj) state_d = IDLE;
            else if (os_q == LAST)    state_d = DATA;
          end
          DATA: begin
            if (os_q == SAMP2) begin
              shift_d = {maj, shift_q[DATA_W-1:1]};
              bit_d   = bit_q + BW'(1);
            end
            if (os_q == LAST && bit_q == BW'(DATA_W)) state_d = par_en_q ? PARITY : STOP;
          end
          PARITY: begin
            if (os_q == SAMP2) perr_acc_d = (^shift_q) ^ maj ^ par_odd_q;
            if (os_q == LAST)  state_d = STOP;
          end
          STOP: begin
            if (os_q == SAMP2) begin
              ferr_acc_d = ferr_acc_q | ~maj;
              if (!(two_stop_q && !stop_idx_q)) begin
                done_d  = 1'b1;
                os_d    = '0;
                state_d = (ferr_acc_q | ~maj) ? WAIT_HIGH : IDLE;
              end
            end
            if (os_q == LAST) stop_idx_d = 1'b1;
          end
          WAIT_HIGH: begin
            // Count consecutive high ticks so a long break yields a single word.
            if (!rx_s)              os_d = '0;
            else if (os_q == LAST)  state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end

    if (done_q) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        perr_d  = perr_acc_q;
        ferr_d  = ferr_acc_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      div_q      <= '0;
      os_q       <= '0;
      bit_q      <= '0;
      stop_idx_q <= 1'b0;
      samp_q     <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      div_q      <= div_d;
      os_q       <= os_d;
      bit_q      <= bit_d;
      stop_idx_q <= stop_idx_d;
      samp_q     <= samp_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      two_stop_q <= two_stop_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      done_q     <= done_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
      busy_q     <= busy_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Randomized plus directed bench for uart_rx_cfg; a serial driver pushes expected
// words into a scoreboard queue and an independent monitor checks every handshake.
module tb_uart_rx_cfg;
  localparam int OVS = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        stop2;
  logic        rx_serial;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        parity_err, frame_err, overrun, busy;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   wn;
  logic       held_v = 1'b0;
  logic [7:0] held_d = 8'h00;

  uart_rx_cfg #(.DATA_W(8), .OVS(OVS), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .parity_mode(parity_mode),
    .stop2(stop2), .rx_serial(rx_serial), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic v, input int n);
    rx_serial = v;
    clks(n);
  endtask

  // Builds a frame from the line rules; the expected word and flags come from the same rules.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic s2,
                            input logic pflip, input logic [1:0] stopv, input int bd,
                            input bit push, input int glitch_bit);
    int   bt;
    logic pbit, pen, podd, fe;
    exp_t e;
    bt   = OVS * (bd + 1);
    pen  = (pm == 2'b01) || (pm == 2'b10);
    podd = (pm == 2'b10);
    pbit = (^d) ^ podd ^ pflip;
    fe   = ~stopv[0] | (s2 & ~stopv[1]);
    e.d  = d;
    e.pe = pen && (((^d) ^ pbit) != podd);
    e.fe = fe;
    if (push) exp_q.push_back(e);
    $display("[TB] frame data=%02h pm=%0d stop2=%0d pflip=%0d stops=%b bd=%0d exp_pe=%0d exp_fe=%0d",
             d, pm, s2, pflip, stopv, bd, e.pe, e.fe);
    baud_div    = 16'(bd);
    parity_mode = pm;
    stop2       = s2;
    drive(1'b0, bt);
    parity_mode = 2'($urandom);
    stop2       = 1'($urandom);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        drive(d[i], bt / 2);
        drive(~d[i], bd + 1);
        drive(d[i], bt - bt / 2 - (bd + 1));
      end else begin
        drive(d[i], bt);
      end
    end
    if (pen) drive(pbit, bt);
    drive(stopv[0], bt);
    if (s2) drive(stopv[1], bt);
    drive(1'b1, 2 * bt);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: one comparison per accepted word, plus hold-stability while stalled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        held_v = 1'b0;
      end else begin
        if (held_v && rx_valid) check("hold_data", {24'h0, rx_data}, {24'h0, held_d});
        if (rx_valid && rx_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_word: got %02h pe=%0d fe=%0d expected none",
                     rx_data, parity_err, frame_err);
          end else begin
            e = exp_q.pop_front();
            $display("[TB] word got=%02h pe=%0d fe=%0d exp=%02h pe=%0d fe=%0d",
                     rx_data, parity_err, frame_err, e.d, e.pe, e.fe);
            check("word_data", {24'h0, rx_data}, {24'h0, e.d});
            check("word_perr", {31'h0, parity_err}, {31'h0, e.pe});
            check("word_ferr", {31'h0, frame_err}, {31'h0, e.fe});
          end
        end
        held_v = rx_valid && !rx_ready;
        held_d = rx_data;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; rx_serial = 1'b1; rx_ready = 1'b1;
    baud_div = 16'd0; parity_mode = 2'b00; stop2 = 1'b0;
    clks(3);
    check("rst_valid", {31'h0, rx_valid}, 32'd0);
    check("rst_data", {24'h0, rx_data}, 32'd0);
    check("rst_flags", {29'h0, parity_err, frame_err, overrun}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    rst = 1'b1;
    clks(4);

    // 8N1 0xD7 at full tick rate
    send_frame(8'hD7, 2'b00, 1'b0, 1'b0, 2'b11, 0, 1'b1, -1);
    // parity: 8E1 wrong parity, 8O1 correct parity bit 1
    send_frame(8'hA5, 2'b01, 1'b0, 1'b1, 2'b11, 0, 1'b1, -1);
    send_frame(8'hA5, 2'b10, 1'b0, 1'b0, 2'b11, 1, 1'b1, -1);
    // mode 11 behaves as no parity
    send_frame(8'h3E, 2'b11, 1'b0, 1'b0, 2'b11, 0, 1'b1, -1);
    drain();

    // false start: low for 6 ticks
    baud_div = 16'd1;
    drive(1'b0, 6 * 2);
    check("false_start_busy", {31'h0, busy}, 32'd1);
    drive(1'b1, 4 * OVS * 2);
    check("false_start_idle", {31'h0, busy}, 32'd0);

    // one-tick glitch inside a data bit
    send_frame(8'h5A, 2'b00, 1'b0, 1'b0, 2'b11, 3, 1'b1, 2);
    send_frame(8'h5A, 2'b01, 1'b0, 1'b0, 2'b11, 3, 1'b1, 5);

    // 8N2 with second stop low
    send_frame(8'h96, 2'b00, 1'b1, 1'b0, 2'b01, 0, 1'b1, -1);
    drain();

    // 20-bit break
    baud_div = 16'd0; parity_mode = 2'b00; stop2 = 1'b0;
    exp_q.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b1});
    drive(1'b0, 20 * OVS);
    drive(1'b1, 8);
    check("break_wait_busy", {31'h0, busy}, 32'd1);
    drive(1'b1, 22);
    check("break_idle", {31'h0, busy}, 32'd0);
    drain();

    // overrun: two frames with consumer stalled
    rx_ready = 1'b0;
    send_frame(8'h11, 2'b00, 1'b0, 1'b0, 2'b11, 0, 1'b1, -1);
    send_frame(8'h22, 2'b00, 1'b0, 1'b0, 2'b11, 0, 1'b0, -1);
    check("ovr_set", {31'h0, overrun}, 32'd1);
    check("ovr_valid", {31'h0, rx_valid}, 32'd1);
    check("ovr_held", {24'h0, rx_data}, 32'h11);
    rx_ready = 1'b1;
    drain();
    check("ovr_sticky", {31'h0, overrun}, 32'd1);
    rst = 1'b0;
    clks(2);
    check("ovr_reset", {31'h0, overrun}, 32'd0);
    rst = 1'b1;
    clks(4);

    // accept on the completion clk of the second frame
    rx_ready = 1'b0;
    send_frame(8'h11, 2'b00, 1'b0, 1'b0, 2'b11, 0, 1'b1, -1);
    fork
      send_frame(8'h22, 2'b00, 1'b0, 1'b0, 2'b11, 0, 1'b1, -1);
      begin
        wn = 0;
        while (busy !== 1'b1 && wn < 5000) begin @(negedge clk); wn++; end
        while (busy !== 1'b0 && wn < 5000) begin @(negedge clk); wn++; end
        check("busy_fall_wait", {31'h0, (wn < 5000)}, 32'd1);
        rx_ready = 1'b1;
      end
    join
    drain();
    check("same_clk_no_ovr", {31'h0, overrun}, 32'd0);

    // reset during the fourth data bit
    baud_div = 16'd1; parity_mode = 2'b00; stop2 = 1'b0;
    drive(1'b0, 2 * OVS);
    drive(1'b1, 3 * 2 * OVS);
    drive(1'b1, OVS);
    rst = 1'b0;
    clks(3);
    check("midrst_valid", {31'h0, rx_valid}, 32'd0);
    check("midrst_data", {24'h0, rx_data}, 32'd0);
    check("midrst_flags", {29'h0, parity_err, frame_err, overrun}, 32'd0);
    check("midrst_busy", {31'h0, busy}, 32'd0);
    rst = 1'b1;
    drive(1'b1, 4 * OVS);
    check("midrst_stay_idle", {31'h0, busy}, 32'd0);
    send_frame(8'h3C, 2'b00, 1'b0, 1'b0, 2'b11, 1, 1'b1, -1);
    drain();

    // randomized frames
    for (int k = 0; k < 24; k++) begin
      logic [1:0] sv;
      sv = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b11;
      send_frame(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                 sv, int'($urandom_range(0, 3)), 1'b1, -1);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter DATA_W, 8, data bits per frame; legal range 5..9.
REQ-002 Parameter OVS, 16, oversample ticks per bit; even, legal range 8..32.
REQ-003 Parameter DIV_W, 16, width of baud_div.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-low.
REQ-006 baud_div  input  DIV_W  one oversample tick every baud_div+1 clk cycles; 0 = tick every clk.
REQ-007 parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-008 stop2  input  1  1 = two stop bits checked, 0 = one.
REQ-009 rx_serial  input  1  asynchronous serial line, idle high.
REQ-010 rx_data  output  DATA_W  received word, LSB first on line.
REQ-011 rx_valid  output  1  rx_data and error flags valid.
REQ-012 rx_ready  input  1  consumer accepts word when rx_valid & rx_ready.
REQ-013 parity_err  output  1  parity mismatch for the held word.
REQ-014 frame_err  output  1  a stop bit sampled low for the held word.
REQ-015 overrun  output  1  sticky; a frame completed while rx_valid=1 and rx_ready=0.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 rx_serial shall pass through a 2-flop synchronizer; all references below are to the synchronized value.
REQ-018 Tick counter shall count 0..baud_div, emit a one-clk tick at baud_div, then wrap to 0; it shall be held at 0 in IDLE and restart on start detection.
REQ-019 States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-020 IDLE -> START on a synchronized high-to-low transition; parity_mode and stop2 shall be latched at this point and held for the frame.
REQ-021 Each bit shall be decided by a 2-of-3 majority of samples at ticks OVS/2-1, OVS/2 and OVS/2+1 within the bit; bit period = OVS ticks.
REQ-022 START: a majority of 1 is a false start and returns to IDLE with no flags set; a majority of 0 proceeds to DATA.
REQ-023 DATA shall shift in exactly DATA_W bits LSB first, then go to PARITY if the latched mode is 01/10, else to STOP.
REQ-024 Parity check: even = XOR(data, parity bit) must be 0; odd = XOR must be 1; any mismatch sets the frame's parity_err.
REQ-025 STOP shall check one stop bit, or two if stop2 is latched; any stop sample of 0 sets the frame's frame_err.
REQ-026 Frame completion is the clk after the final stop-bit decision; at completion rx_data, parity_err and frame_err shall load together and rx_valid shall rise, unless the output register is still full.
REQ-027 rx_valid shall hold, with rx_data and flags stable, until a clk where rx_ready=1; it shall clear on that clk.
REQ-028 If the output register is full at completion, the new word shall be discarded, the held word kept and overrun set; overrun clears only on reset.
REQ-029 If the output is accepted on the same clk as a completion, the new word shall load and rx_valid shall stay 1 with no overrun.
REQ-030 After frame_err the FSM shall enter WAIT_HIGH and return to IDLE only after the line is high for one full bit (OVS ticks), so a break is reported once.
REQ-031 Otherwise STOP -> IDLE at completion; a new start edge shall be accepted on the next clk.
REQ-032 Changes to baud_div mid-frame are unsupported; changes to parity_mode and stop2 take effect at the next frame.

Reset
REQ-033 While rst=0: state IDLE, counters 0, synchronizer flops 1, rx_data 0, rx_valid 0, parity_err 0, frame_err 0, overrun 0, busy 0.
REQ-034 Reset asserted mid-frame shall abort the frame with no output update; after release the block waits in IDLE for a fresh start edge.

Verification
REQ-035 baud_div=0, OVS=16, 8N1, byte 0xD7, rx_ready=1 -> rx_valid pulses for 1 clk with rx_data=0xD7 and all flags 0.
REQ-036 8E1 with 0xA5 and a wrong parity bit (1) -> rx_data=0xA5, parity_err=1; repeat with 8O1 and correct parity bit 1 -> parity_err=0.
REQ-037 Line low for 6 ticks then high -> returns to IDLE, no rx_valid; a 1-tick glitch inside a data bit -> majority vote still yields the correct bit.
REQ-038 8N2 with second stop bit low -> frame_err=1; a 20-bit-long break -> exactly one word 0x00 with frame_err=1, and IDLE only after the line is high for 16 ticks.
REQ-039 Two frames 0x11, 0x22 with rx_ready=0 -> rx_data stays 0x11 and overrun=1; with rx_ready raised on the completion clk of the second frame -> rx_data=0x22 and overrun=0.
REQ-040 rst pulsed low during the fourth data bit -> all outputs return to reset values; the next full frame 0x3C is received correctly.
